// File: rtl/acc_alu_exec_if.sv
// Request/writeback bundle between the register file side and the execute stage.
interface acc_alu_exec_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 3
);
   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op_code;
   logic [ADDR_W-1:0] op_dst;
   logic [WIDTH-1:0]  acc_in;
   logic [WIDTH-1:0]  b_in;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [WIDTH-1:0]  wb_data;
   logic              carry_flag;
   logic              zero_flag;
   logic              busy;

   modport master (
      output op_valid, op_code, op_dst, acc_in, b_in,
      input  op_ready, wb_en, wb_addr, wb_data, carry_flag, zero_flag, busy
   );

   modport slave (
      input  op_valid, op_code, op_dst, acc_in, b_in,
      output op_ready, wb_en, wb_addr, wb_data, carry_flag, zero_flag, busy
   );
endinterface

// File: rtl/acc_alu_exec.sv
// Accumulator ALU execute stage: single-cycle logic/arith ops, iterative SHL and
// shift-add MUL, result returned through the register-file write port.
module acc_alu_exec #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input logic           clk,
   input logic           reset_n,
   acc_alu_exec_if.slave bus
);
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MOV = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic [1:0]        r_state,  w_state_nxt;
   logic [2:0]        r_op,     w_op_nxt;
   logic [ADDR_W-1:0] r_dst,    w_dst_nxt;
   logic [WIDTH-1:0]  r_res,    w_res_nxt;
   logic [WIDTH-1:0]  r_hi,     w_hi_nxt;
   logic [PW-1:0]     r_mcand,  w_mcand_nxt;
   logic [WIDTH-1:0]  r_mplier, w_mplier_nxt;
   logic              r_cy,     w_cy_nxt;
   logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;

   logic              r_ready, r_busy, r_wb_en, r_carry, r_zero;
   logic [ADDR_W-1:0] r_wb_addr;
   logic [WIDTH-1:0]  r_wb_data;

   logic [WIDTH:0]    w_sum, w_diff;
   logic [PW-1:0]     w_prod;

   assign w_sum  = {1'b0, bus.acc_in} + {1'b0, bus.b_in};
   assign w_diff = {1'b0, bus.acc_in} - {1'b0, bus.b_in};
   // One shift-add step: {r_hi,r_res} is the running product.
   assign w_prod = {r_hi, r_res} + (r_mplier[0] ? r_mcand : '0);

   // Next-state and datapath update
   always_comb begin
      w_state_nxt  = r_state;
      w_op_nxt     = r_op;
      w_dst_nxt    = r_dst;
      w_res_nxt    = r_res;
      w_hi_nxt     = r_hi;
      w_mcand_nxt  = r_mcand;
      w_mplier_nxt = r_mplier;
      w_cy_nxt     = r_cy;
      w_cnt_nxt    = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.op_valid) begin
               w_op_nxt    = bus.op_code;
               w_dst_nxt   = bus.op_dst;
               w_state_nxt = S_WB;
               w_cy_nxt    = 1'b0;
               case (bus.op_code)
                  OP_ADD: {w_cy_nxt, w_res_nxt} = w_sum;
                  OP_SUB: {w_cy_nxt, w_res_nxt} = w_diff;
                  OP_AND: w_res_nxt = bus.acc_in & bus.b_in;
                  OP_OR:  w_res_nxt = bus.acc_in | bus.b_in;
                  OP_XOR: w_res_nxt = bus.acc_in ^ bus.b_in;
                  OP_MOV: w_res_nxt = bus.b_in;
                  OP_SHL: begin
                     w_res_nxt = bus.acc_in;
                     w_cnt_nxt = CNT_W'(bus.b_in[2:0]);
                     if (bus.b_in[2:0] != 3'd0) w_state_nxt = S_ITER;
                  end
                  default: begin
                     w_res_nxt    = '0;
                     w_hi_nxt     = '0;
                     w_mcand_nxt  = PW'(bus.acc_in);
                     w_mplier_nxt = bus.b_in;
                     w_cnt_nxt    = CNT_W'(WIDTH);
                     w_state_nxt  = S_ITER;
                  end
               endcase
            end
         end
         S_ITER: begin
            if (r_op == OP_SHL) begin
               w_res_nxt = {r_res[WIDTH-2:0], 1'b0};
               w_cy_nxt  = r_res[WIDTH-1];
            end else begin
               {w_hi_nxt, w_res_nxt} = w_prod;
               w_mcand_nxt  = {r_mcand[PW-2:0], 1'b0};
               w_mplier_nxt = {1'b0, r_mplier[WIDTH-1:1]};
               w_cy_nxt     = |w_prod[PW-1:WIDTH];
            end
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) w_state_nxt = S_WB;
         end
         S_WB:    w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_op      <= OP_ADD;
         r_dst     <= '0;
         r_res     <= '0;
         r_hi      <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cy      <= 1'b0;
         r_cnt     <= '0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_wb_en   <= 1'b0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
         r_carry   <= 1'b0;
         r_zero    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_op     <= w_op_nxt;
         r_dst    <= w_dst_nxt;
         r_res    <= w_res_nxt;
         r_hi     <= w_hi_nxt;
         r_mcand  <= w_mcand_nxt;
         r_mplier <= w_mplier_nxt;
         r_cy     <= w_cy_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ready  <= (w_state_nxt == S_IDLE);
         r_busy   <= (w_state_nxt != S_IDLE);
         r_wb_en  <= (w_state_nxt == S_WB);
         if (w_state_nxt == S_WB) begin
            r_wb_addr <= w_dst_nxt;
            r_wb_data <= w_res_nxt;
         end
         // Flags commit together with the register-file write
         if (r_state == S_WB) begin
            r_zero <= (r_wb_data == '0);
            if (r_op != OP_MOV) r_carry <= r_cy;
         end
      end
   end

   assign bus.op_ready   = r_ready;
   assign bus.busy       = r_busy;
   assign bus.wb_en      = r_wb_en;
   assign bus.wb_addr    = r_wb_addr;
   assign bus.wb_data    = r_wb_data;
   assign bus.carry_flag = r_carry;
   assign bus.zero_flag  = r_zero;
endmodule
